// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and bit-period helper.
// Intended for reuse by the receive side as well.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
// Push when full and pop when empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a bit-timing FSM and shifter.
//   state | meaning
//   IDLE  | line high, waiting for the FIFO to hold a byte
//   START | start bit (low) on the line
//   DATA  | data bits, LSB first, one per bit period
//   STOP  | stop bit (high); chains straight into the next START if a byte is queued
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [7:0]                  data_in,
  input  logic                        valid,
  output logic                        ready,
  output logic                        TXD,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_tx: only one stop bit is supported");
  end

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             txd_q, txd_d;
  logic             pop;
  logic             push;
  logic             bit_done;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  assign ready    = !fifo_full && !RESET;
  assign push     = valid && ready;
  assign bit_done = (div_q == DIV_LAST);
  assign TXD      = txd_q;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      txd_q     <= txd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = bit_done ? '0 : div_q + DIV_W'(1);
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          txd_d     = sh_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == BIT_LAST) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            sh_d      = {1'b0, sh_q[7:1]};
            txd_d     = sh_q[1];
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        // Chaining here rather than via IDLE keeps back-to-back frames gap-free.
        if (bit_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = fifo_dout;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle frame-position reference model plus an independent line decoder.
module tb_uart_tx;

  localparam int CLK_HZ = 40;
  localparam int BAUD_R = 10;
  localparam int CPB    = 4;
  localparam int FRAME  = 10 * CPB;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          valid = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          ready;
  logic          TXD;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .data_in    (data_in),
    .valid      (valid),
    .ready      (ready),
    .TXD        (TXD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model: queued bytes plus position within the frame on the line
  logic [7:0]    m_fifo[$];
  logic [7:0]    m_accepted[$];
  logic          m_active = 1'b0;
  int            m_pos = 0;
  logic [7:0]    m_cur = 8'h00;
  logic          m_pushed = 1'b0;
  logic          m_txd = 1'b1;
  logic          m_busy = 1'b0;
  logic          m_ready = 1'b0;
  logic [CW-1:0] m_count = '0;

  // line decoder: samples the middle of each bit after a falling start edge
  logic [7:0]    dec_q[$];
  logic          dec_active = 1'b0;
  int            dec_c = 0;
  logic [7:0]    dec_byte = 8'h00;
  int            dec_ferr = 0;

  task automatic step(input logic v, input logic [7:0] d, input logic rst);
    logic full_pre, empty_pre, do_push, do_pop;
    int bit_n;
    valid     = v;
    data_in   = d;
    RESET     = rst;
    full_pre  = (m_fifo.size() == DEPTH);
    empty_pre = (m_fifo.size() == 0);
    do_push   = v && !full_pre && !rst;
    do_pop    = !rst && !empty_pre && (!m_active || m_pos == FRAME - 1);
    @(posedge CLK);
    m_pushed = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      if (do_pop) begin
        m_cur    = m_fifo.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else m_pos++;
      end
      if (do_push) begin
        m_fifo.push_back(d);
        m_accepted.push_back(d);
        m_pushed = 1'b1;
      end
    end
    if (!m_active) m_txd = 1'b1;
    else begin
      bit_n = m_pos / CPB;
      if (bit_n == 0) m_txd = 1'b0;
      else if (bit_n <= 8) m_txd = m_cur[bit_n-1];
      else m_txd = 1'b1;
    end
    m_busy  = m_active || (m_fifo.size() != 0);
    m_count = CW'(m_fifo.size());
    m_ready = (m_fifo.size() < DEPTH) && !rst;
    #1;
    if (rst) dec_active = 1'b0;
    else if (!dec_active) begin
      if (TXD === 1'b0) begin
        dec_active = 1'b1;
        dec_c      = 0;
        dec_byte   = 8'h00;
      end
    end else begin
      dec_c++;
      if (dec_c >= 6 && dec_c <= 34 && (dec_c % CPB) == 2) dec_byte[(dec_c-6)/CPB] = TXD;
      if (dec_c == 38 && TXD !== 1'b1) dec_ferr++;
      if (dec_c == FRAME - 1) begin
        dec_active = 1'b0;
        dec_q.push_back(dec_byte);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h12, 1'b1);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL reset txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if ({TXD, busy, ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL reset_release txd/busy/ready/count got %b/%b/%b/%0d want 1/0/1/0",
               TXD, busy, ready, fifo_count);
    end
  endtask

  task automatic test_single();
    dec_q.delete();
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (TXD !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latency txd/busy got %b/%b want 0/1", TXD, busy);
    end
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL single cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (busy !== 1'b0 || TXD !== 1'b1) begin
      bad++;
      $display("FAIL single_end busy/txd got %b/%b want 0/1", busy, TXD);
    end
    total++;
    if (dec_q.size() != 1 || dec_q[0] !== 8'h55) begin
      bad++;
      $display("FAIL single_decode got %0d bytes first %h want 1 byte 55", dec_q.size(),
               (dec_q.size() > 0) ? dec_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$] = '{8'hA3, 8'h0F};
    dec_q.delete();
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 85; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL b2b cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (dec_q.size() != exp.size()) begin
      bad++;
      $display("FAIL b2b_count got %0d want %0d", dec_q.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        total++;
        if (dec_q[i] !== exp[i]) begin
          bad++;
          $display("FAIL b2b_byte%0d got %h want %h", i, dec_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_hold_valid();
    logic [7:0] b[6];
    logic [7:0] r;
    logic [CW-1:0] peak;
    int idx;
    r = 8'($urandom_range(0, 255));
    foreach (b[i]) b[i] = 8'(r + i * 41);
    dec_q.delete();
    idx  = 0;
    peak = '0;
    for (int c = 0; c < 320; c++) begin
      step(idx < 6, (idx < 6) ? b[idx] : 8'h00, 1'b0);
      if (m_pushed) idx++;
      if (fifo_count > peak) peak = fifo_count;
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL hold cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 c, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (peak !== 3'd4) begin
      bad++;
      $display("FAIL hold_peak got %0d want 4", peak);
    end
    total++;
    if (dec_q.size() != 6) begin
      bad++;
      $display("FAIL hold_count got %0d want 6", dec_q.size());
    end else begin
      foreach (b[i]) begin
        total++;
        if (dec_q[i] !== b[i]) begin
          bad++;
          $display("FAIL hold_byte%0d got %h want %h", i, dec_q[i], b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    dec_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(r + i * 37), 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL rstmid_pre cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    step(1'b0, 8'h00, 1'b1);
    total++;
    if ({TXD, busy, fifo_count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL rstmid txd/busy/count got %b/%b/%0d want 1/0/0", TXD, busy, fifo_count);
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL rstmid_post cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (dec_q.size() != 0) begin
      bad++;
      $display("FAIL rstmid_frames got %0d want 0", dec_q.size());
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] x[4];
    logic [7:0] r;
    int c;
    r = 8'($urandom_range(0, 255));
    foreach (x[i]) x[i] = 8'(r + i * 53);
    dec_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, x[i], 1'b0);
    c = 0;
    while (!(m_active && m_pos == FRAME - 1) && c < 60) begin
      step(1'b0, 8'h00, 1'b0);
      c++;
    end
    total++;
    if (c >= 60) begin
      bad++;
      $display("FAIL pushpop_timeout got %0d cycles want <60", c);
    end
    total++;
    if (fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL pushpop_pre count got %0d want 2", fifo_count);
    end
    step(1'b1, x[3], 1'b0);
    total++;
    if (fifo_count !== 3'd2 || TXD !== 1'b0) begin
      bad++;
      $display("FAIL pushpop count/txd got %0d/%b want 2/0", fifo_count, TXD);
    end
    for (int i = 0; i < 140; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL pushpop cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (dec_q.size() != 4) begin
      bad++;
      $display("FAIL pushpop_count got %0d want 4", dec_q.size());
    end else begin
      foreach (x[i]) begin
        total++;
        if (dec_q[i] !== x[i]) begin
          bad++;
          $display("FAIL pushpop_byte%0d got %h want %h", i, dec_q[i], x[i]);
        end
      end
    end
  endtask

  task automatic test_full_ignore();
    logic [7:0] y[5];
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    foreach (y[i]) y[i] = 8'(r + i * 29) & 8'h7F;
    dec_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, y[i], 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'hEE, 1'b0);
      total++;
      if (ready !== 1'b0 || fifo_count !== 3'd4) begin
        bad++;
        $display("FAIL full_hold ready/count got %b/%0d want 0/4", ready, fifo_count);
      end
    end
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 8'h00, 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL full cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (dec_q.size() != 5) begin
      bad++;
      $display("FAIL full_count got %0d want 5", dec_q.size());
    end else begin
      foreach (y[i]) begin
        total++;
        if (dec_q[i] !== y[i]) begin
          bad++;
          $display("FAIL full_byte%0d got %h want %h", i, dec_q[i], y[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    m_accepted.delete();
    dec_q.delete();
    dec_ferr = 0;
    for (int i = 0; i < 700; i++) begin
      step((i < 500) && ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 255)), 1'b0);
      total++;
      if ({TXD, busy, ready, fifo_count} !== {m_txd, m_busy, m_ready, m_count}) begin
        bad++;
        $display("FAIL random cyc%0d txd/busy/ready/count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, TXD, busy, ready, fifo_count, m_txd, m_busy, m_ready, m_count);
      end
    end
    total++;
    if (dec_ferr != 0) begin
      bad++;
      $display("FAIL random_stopbit got %0d framing errors want 0", dec_ferr);
    end
    total++;
    if (dec_q.size() != m_accepted.size()) begin
      bad++;
      $display("FAIL random_count got %0d want %0d", dec_q.size(), m_accepted.size());
    end else begin
      foreach (m_accepted[i]) begin
        total++;
        if (dec_q[i] !== m_accepted[i]) begin
          bad++;
          $display("FAIL random_byte%0d got %h want %h", i, dec_q[i], m_accepted[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_push_pop();
    test_full_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
